// File: rtl/stack_mc_ctrl.sv
// rtl/stack_mc_ctrl.sv - multicycle control FSM for a stack-machine datapath.
// Define STACK_GUARD_EN to enable stack depth tracking and under/overflow guarding.
module stack_mc_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 OPC,
  input  logic                       mem_ready,
  output logic                       push,
  output logic                       pop,
  output logic                       tos,
  output logic                       PCWrite,
  output logic                       PCWriteCond,
  output logic                       IorD,
  output logic                       MemWrite,
  output logic                       MemRead,
  output logic                       IRWrite,
  output logic                       StackSrc,
  output logic                       ldA,
  output logic                       ldB,
  output logic                       ALUSrcB,
  output logic                       PCSrc,
  output logic [1:0]                 ALUSrcA,
  output logic [1:0]                 ALUControl,
  output logic                       halted,
  output logic                       fault,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [4:0] {
    S_IF, S_ID, S_POP1, S_LDA, S_POP2, S_LDB, S_EXE, S_EXEN, S_PUSHR,
    S_POPM, S_LDM, S_MEMW, S_MEMR, S_PUSHM, S_TOSR, S_LDJ, S_BRZ, S_JMPS,
    S_HALTED, S_FAULT
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] op_q;
  logic       guard_ok;

  // OPC is only valid in ID; keep the low bits for the ALU op and NOT detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 2'b00;
    end else if (state == S_ID) begin
      op_q <= OPC[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IF;
    end else begin
      state <= state_nx;
    end
  end

`ifdef STACK_GUARD_EN
  logic [DW-1:0] depth_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push && !pop && depth_q != DW'(DEPTH)) begin
      depth_q <= depth_q + 1'b1;
    end else if (pop && !push && depth_q != '0) begin
      depth_q <= depth_q - 1'b1;
    end
  end

  always_comb begin
    guard_ok = 1'b1;
    case (OPC)
      4'b0000, 4'b0001, 4'b0010: guard_ok = (depth_q >= DW'(2));
      4'b0011, 4'b0101, 4'b0111: guard_ok = (depth_q != '0);
      4'b0100:                   guard_ok = (depth_q < DW'(DEPTH));
      default:                   guard_ok = 1'b1;
    endcase
  end

  assign depth = depth_q;
`else
  assign guard_ok = 1'b1;
  assign depth    = '0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IF: begin
        if (mem_ready) state_nx = S_ID;
      end
      S_ID: begin
        if (OPC == 4'b1111) begin
          state_nx = S_HALTED;
        end else if (OPC[3] || !guard_ok) begin
          state_nx = S_FAULT;
        end else begin
          case (OPC[2:0])
            3'd0, 3'd1, 3'd2: state_nx = S_POP1;
            3'd3:             state_nx = S_POP2;
            3'd4:             state_nx = S_MEMR;
            3'd5:             state_nx = S_POPM;
            3'd6:             state_nx = S_JMPS;
            default:          state_nx = S_TOSR;
          endcase
        end
      end
      S_POP1:   state_nx = S_LDA;
      S_LDA:    state_nx = S_POP2;
      S_POP2:   state_nx = S_LDB;
      // NOT shares the second-operand path; its op bits are 11
      S_LDB:    state_nx = (op_q == 2'b11) ? S_EXEN : S_EXE;
      S_EXE:    state_nx = S_PUSHR;
      S_EXEN:   state_nx = S_PUSHR;
      S_PUSHR:  state_nx = S_IF;
      S_POPM:   state_nx = S_LDM;
      S_LDM:    state_nx = S_MEMW;
      S_MEMW: begin
        if (mem_ready) state_nx = S_IF;
      end
      S_MEMR: begin
        if (mem_ready) state_nx = S_PUSHM;
      end
      S_PUSHM:  state_nx = S_IF;
      S_TOSR:   state_nx = S_LDJ;
      S_LDJ:    state_nx = S_BRZ;
      S_BRZ:    state_nx = S_IF;
      S_JMPS:   state_nx = S_IF;
      S_HALTED: state_nx = S_HALTED;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_FAULT;
    endcase
  end

  // Outputs are gated by rst so every strobe drops the moment reset rises.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    StackSrc    = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    ALUSrcB     = 1'b0;
    PCSrc       = 1'b0;
    ALUSrcA     = 2'b00;
    ALUControl  = 2'b00;
    halted      = 1'b0;
    fault       = 1'b0;
    if (!rst) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_POP1, S_POP2, S_POPM: pop = 1'b1;
        S_LDA, S_LDM, S_LDJ:    ldA = 1'b1;
        S_LDB:                  ldB = 1'b1;
        S_EXE: begin
          ALUSrcA    = 2'b10;
          ALUControl = op_q;
        end
        S_EXEN: begin
          ALUSrcA    = 2'b01;
          ALUControl = 2'b01;
        end
        S_PUSHR: push = 1'b1;
        S_MEMW: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_MEMR: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_PUSHM: begin
          StackSrc = 1'b1;
          push     = 1'b1;
        end
        S_TOSR: tos = 1'b1;
        S_BRZ: begin
          PCWriteCond = 1'b1;
          PCSrc       = 1'b1;
        end
        S_JMPS: begin
          PCSrc   = 1'b1;
          PCWrite = 1'b1;
        end
        S_HALTED: halted = 1'b1;
        S_FAULT:  fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
